// File: rtl/booth_mult_if.sv
// booth_mult_if: start/operand/result bundle for the Booth multiplier.
//   ctrl_MULT      start pulse (master -> slave)
//   data_operandA  32-bit signed multiplicand (master -> slave)
//   data_operandB  32-bit signed multiplier (master -> slave)
//   data_result    low 32 bits of the signed product (slave -> master)
//   data_exception signed overflow flag, held with data_result (slave -> master)
//   data_resultRDY one-cycle done pulse (slave -> master)
interface booth_mult_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/booth_mult.sv
// booth_mult: 32x32 signed multiplier, radix-4 modified Booth, 16 steps.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    booth_mult_if.slave (start, operands, result, exception, ready)
// A start edge in any state latches the operands and (re)starts the
// operation; the result and exception flag are registered on the final
// step and held until the next completed product. resultRDY is high for
// exactly the one cycle spent in DONE.
module booth_mult (
  input  logic        clock,
  input  logic        reset,
  booth_mult_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT       state;
  stateT       nextState;

  logic        start;
  logic        stepEn;
  logic        lastStep;

  logic [31:0] mcand;
  logic [31:0] mulQ;
  logic        qMinus1;
  logic [33:0] acc;
  logic [4:0]  stepCnt;

  logic [33:0] mExt;
  logic [33:0] addend;
  logic        carryIn;
  logic [33:0] sum;
  logic [33:0] accNext;
  logic [31:0] qNext;
  logic [63:0] product;

  always_comb begin
    start    = bus.ctrl_MULT;
    lastStep = (stepCnt == 5'd15);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; a start edge always wins, aborting any operation
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = BUSY;
      BUSY: begin
        if (start)         nextState = BUSY;
        else if (lastStep) nextState = DONE;
      end
      DONE:    nextState = start ? BUSY : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stepEn             = (state == BUSY);
    bus.data_resultRDY = (state == DONE);
  end

  // Booth digit from {Q[1],Q[0],q_-1}; negatives as one's complement + carry
  always_comb begin
    mExt    = {{2{mcand[31]}}, mcand};
    addend  = '0;
    carryIn = 1'b0;
    case ({mulQ[1:0], qMinus1})
      3'b001, 3'b010: addend = mExt;
      3'b011:         addend = {mExt[32:0], 1'b0};
      3'b100: begin
        addend  = ~{mExt[32:0], 1'b0};
        carryIn = 1'b1;
      end
      3'b101, 3'b110: begin
        addend  = ~mExt;
        carryIn = 1'b1;
      end
      default:        addend = '0;
    endcase
    sum     = acc + addend + {33'd0, carryIn};
    // Arithmetic shift right by 2 across {acc, Q}
    accNext = {{2{sum[33]}}, sum[33:2]};
    qNext   = {sum[1:0], mulQ[31:2]};
    product = {accNext[31:0], qNext};
  end

  // Datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand              <= '0;
      mulQ               <= '0;
      qMinus1            <= 1'b0;
      acc                <= '0;
      stepCnt            <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
    end else if (start) begin
      mcand   <= bus.data_operandA;
      mulQ    <= bus.data_operandB;
      qMinus1 <= 1'b0;
      acc     <= '0;
      stepCnt <= '0;
    end else if (stepEn) begin
      acc     <= accNext;
      mulQ    <= qNext;
      qMinus1 <= mulQ[1];
      stepCnt <= stepCnt + 5'd1;
      // Result is taken from the final step's shifted values so it is
      // visible in the same cycle that resultRDY rises.
      if (lastStep) begin
        bus.data_result    <= product[31:0];
        bus.data_exception <= (product[63:32] != {32{product[31]}});
      end
    end
  end

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- ctrl_MULT  input  1  start pulse, sampled on the rising edge
- data_operandA  input  32  multiplicand, two's complement, sampled only on a start edge
- data_operandB  input  32  multiplier, two's complement, sampled only on a start edge
- data_result  output  32  low 32 bits of the signed product
- data_exception  output  1  signed overflow flag, valid while data_resultRDY=1
- data_resultRDY  output  1  one-cycle done pulse
REQ-003 The block SHALL be the multiply counterpart of the existing divider, with the same port semantics: start pulse, 32-bit result, exception flag, ready pulse.

Function
REQ-004 The algorithm SHALL be radix-4 modified Booth recoding of data_operandB, with a 34-bit signed accumulator, an arithmetic shift right by 2 per step, and 16 steps.
REQ-005 Booth digit from bits {Q[1],Q[0],q_-1} SHALL be:
- 000/111 -> 0
- 001/010 -> +M
- 011 -> +2M
- 100 -> -2M
- 101/110 -> -M
REQ-006 M SHALL be data_operandA sign-extended to 34 bits; -M and -2M SHALL be formed as the one's complement plus carry-in 1.
REQ-007 The state machine SHALL have the states IDLE, BUSY and DONE:
- IDLE -> BUSY on ctrl_MULT=1
- BUSY -> DONE on the edge at which the step counter reaches 16
- DONE -> IDLE on the next edge, or DONE -> BUSY if ctrl_MULT=1
REQ-008 On a start edge (any state), the block SHALL latch both operands, clear the accumulator, clear q_-1 and set the 5-bit step counter to 0.
REQ-009 Latency SHALL be as follows: with the start sampled at edge k, steps execute at edges k+1..k+16, and data_resultRDY=1 from edge k+16 to edge k+17 (exactly one cycle).
REQ-010 data_result SHALL equal product[31:0] and SHALL hold its value until the next result is produced; it SHALL NOT change during BUSY.
REQ-011 data_exception SHALL be 1 iff product[63:32] is not equal to 32 copies of product[31].
REQ-012 data_exception SHALL hold its value together with data_result.
REQ-013 A ctrl_MULT=1 during BUSY SHALL abort the current operation and restart it with the new operands.
REQ-014 An aborted operation SHALL NOT produce a data_resultRDY pulse.
REQ-015 Operand changes while not on a start edge SHALL have no effect.
REQ-016 Holding ctrl_MULT=1 continuously SHALL restart the operation every cycle, so data_resultRDY is never asserted.
REQ-017 Edge cases SHALL produce exact two's-complement results without special handling: operand 0, operand 0x80000000, and -1 x 0x80000000.

Reset
REQ-018 While reset=1, the block SHALL force state=IDLE, counter=0, accumulator=0, data_result=0x00000000, data_exception=0 and data_resultRDY=0.
REQ-019 reset asserted mid-BUSY SHALL discard the operation; no data_resultRDY SHALL follow.
REQ-020 The first start after reset release SHALL behave per REQ-009.

Verification
REQ-021 The bench SHALL cover:
- Basic: A=3, B=4, start at edge k -> data_resultRDY high only at edge k+16 cycle; data_result=0x0000000C; data_exception=0.
- Signs: A=-7, B=6 -> 0xFFFFFFD6, exc=0; A=-7, B=-6 -> 0x0000002A, exc=0; A=0x80000000, B=1 -> 0x80000000, exc=0.
- Overflow: A=0x7FFFFFFF, B=2 -> 0xFFFFFFFE, exc=1; A=0x00010000, B=0x00010000 -> 0x00000000, exc=1; A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exc=1.
- Restart: start with 5x5, then at step 8 start with 9x9 -> exactly one RDY pulse, 16 cycles after the second start; result 0x00000051.
- Reset: assert reset at step 10 of 100x100 -> outputs 0 immediately (asynchronously); no RDY pulse; next 2x3 start -> 0x00000006 after 16 cycles.
- Random: 10k random signed pairs versus a 64-bit reference model for result, exception and one-pulse RDY timing.
